// File: rtl/fifo_bank_seq.sv
// Sequencer for the IF/OF FIFO buffer bank: fill IF, stream to PEs, capture results in OF, drain.
// Carries no data; only drives FIFO enables and handshake valids around the bank.
module fifo_bank_seq #(
    parameter int unsigned DEPTH_WIDTH = 4,
    parameter int unsigned CNT_WIDTH   = DEPTH_WIDTH + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [CNT_WIDTH-1:0] tile_len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [1:0]           if_fifo_ctrl,
    input  logic [1:0]           if_fifo_resp,
    output logic                 pe_valid_o,
    input  logic                 pe_result_valid_i,
    output logic [1:0]           of_fifo_ctrl,
    input  logic [1:0]           of_fifo_resp,
    output logic                 out_valid_o,
    input  logic                 out_ready_i
);

    localparam logic [CNT_WIDTH-1:0] MaxLen = CNT_WIDTH'(1) << DEPTH_WIDTH;

    typedef enum logic [2:0] {StIdle, StFill, StCompute, StDrain, StDone} state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] len_q, len_d;
    logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_WIDTH-1:0] res_cnt_q, res_cnt_d;
    logic [CNT_WIDTH-1:0] iss_cnt_q, iss_cnt_d;
    logic [CNT_WIDTH-1:0] acc_cnt_q, acc_cnt_d;
    logic                 pe_valid_q, pe_valid_d;
    logic                 out_valid_q, out_valid_d;
    logic                 err_q, err_d;

    logic if_full, if_empty, of_full, of_empty;
    logic if_wr, if_rd, of_wr, of_rd, in_ready, done;

    assign if_full  = if_fifo_resp[0];
    assign if_empty = if_fifo_resp[1];
    assign of_full  = of_fifo_resp[0];
    assign of_empty = of_fifo_resp[1];

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        res_cnt_d   = res_cnt_q;
        iss_cnt_d   = iss_cnt_q;
        acc_cnt_d   = acc_cnt_q;
        err_d       = err_q;
        pe_valid_d  = 1'b0;
        out_valid_d = 1'b0;
        in_ready    = 1'b0;
        if_wr       = 1'b0;
        if_rd       = 1'b0;
        of_wr       = 1'b0;
        of_rd       = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (tile_len_i != '0 && tile_len_i <= MaxLen) begin
                        len_d     = tile_len_i;
                        wr_cnt_d  = '0;
                        rd_cnt_d  = '0;
                        res_cnt_d = '0;
                        iss_cnt_d = '0;
                        acc_cnt_d = '0;
                        err_d     = 1'b0;
                        state_d   = StFill;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StFill: begin
                in_ready = !if_full && (wr_cnt_q < len_q);
                if_wr    = in_valid_i && in_ready;
                if (if_wr) wr_cnt_d = wr_cnt_q + 1'b1;
                if (wr_cnt_q == len_q) state_d = StCompute;
            end
            StCompute: begin
                if_rd      = !if_empty && (rd_cnt_q < len_q);
                pe_valid_d = if_rd;
                if (if_rd) rd_cnt_d = rd_cnt_q + 1'b1;
                // A result arriving while OF is full is lost but still counted, so the tile ends.
                if (pe_result_valid_i) begin
                    if (res_cnt_q < len_q) begin
                        res_cnt_d = res_cnt_q + 1'b1;
                        if (of_full) err_d = 1'b1;
                        else         of_wr = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (res_cnt_q == len_q) state_d = StDrain;
            end
            StDrain: begin
                of_rd = !of_empty && (iss_cnt_q < len_q) && (!out_valid_q || out_ready_i);
                if (of_rd) iss_cnt_d = iss_cnt_q + 1'b1;
                out_valid_d = of_rd ? 1'b1 : (out_ready_i ? 1'b0 : out_valid_q);
                if (out_valid_q && out_ready_i) acc_cnt_d = acc_cnt_q + 1'b1;
                if (acc_cnt_q == len_q) state_d = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (pe_result_valid_i && state_q != StCompute) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            len_q       <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            res_cnt_q   <= '0;
            iss_cnt_q   <= '0;
            acc_cnt_q   <= '0;
            pe_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            res_cnt_q   <= res_cnt_d;
            iss_cnt_q   <= iss_cnt_d;
            acc_cnt_q   <= acc_cnt_d;
            pe_valid_q  <= pe_valid_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign busy_o       = (state_q != StIdle);
    assign done_o       = done;
    assign err_o        = err_q;
    assign in_ready_o   = in_ready;
    assign if_fifo_ctrl = {if_rd, if_wr};
    assign of_fifo_ctrl = {of_rd, of_wr};
    assign pe_valid_o   = pe_valid_q;
    assign out_valid_o  = out_valid_q;

endmodule

// File: tb/tb_fifo_bank_seq.sv
// Directed bench for fifo_bank_seq with occupancy models of both FIFO banks and a 3-cycle PE echo.
module tb_fifo_bank_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic [4:0] tile_len_i;
    logic       busy_o, done_o, err_o;
    logic       in_valid_i, in_ready_o;
    logic [1:0] if_fifo_ctrl, if_fifo_resp;
    logic       pe_valid_o, pe_result_valid_i;
    logic [1:0] of_fifo_ctrl, of_fifo_resp;
    logic       out_valid_o, out_ready_i;

    logic force_if_full, force_of_full, pe_inject;

    always #5 clk = ~clk;

    fifo_bank_seq #(.DEPTH_WIDTH(4), .CNT_WIDTH(5)) dut (
        .clk               (clk),
        .rst               (rst),
        .start_i           (start_i),
        .tile_len_i        (tile_len_i),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .err_o             (err_o),
        .in_valid_i        (in_valid_i),
        .in_ready_o        (in_ready_o),
        .if_fifo_ctrl      (if_fifo_ctrl),
        .if_fifo_resp      (if_fifo_resp),
        .pe_valid_o        (pe_valid_o),
        .pe_result_valid_i (pe_result_valid_i),
        .of_fifo_ctrl      (of_fifo_ctrl),
        .of_fifo_resp      (of_fifo_resp),
        .out_valid_o       (out_valid_o),
        .out_ready_i       (out_ready_i)
    );

    // Environment: FIFO occupancy and PE latency, updated from values sampled mid-cycle.
    int         if_cnt, of_cnt;
    logic [2:0] pe_pipe;
    logic       s_if_wr, s_if_rd, s_of_wr, s_of_rd, s_pe;

    assign if_fifo_resp      = {if_cnt == 0, (if_cnt >= 16) || force_if_full};
    assign of_fifo_resp      = {(of_cnt == 0) && !force_of_full, (of_cnt >= 16) || force_of_full};
    assign pe_result_valid_i = pe_pipe[2] | pe_inject;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            if_cnt  <= 0;
            of_cnt  <= 0;
            pe_pipe <= 3'b000;
        end else begin
            if_cnt  <= if_cnt + (s_if_wr ? 1 : 0) - (s_if_rd ? 1 : 0);
            if (s_of_wr && !s_of_rd) of_cnt <= of_cnt + 1;
            else if (!s_of_wr && s_of_rd && of_cnt > 0) of_cnt <= of_cnt - 1;
            pe_pipe <= {pe_pipe[1:0], s_pe};
        end
    end

    // Monotonic event counters and protocol-violation counter.
    int   n_if_wr = 0, n_if_rd = 0, n_of_wr = 0, n_of_rd = 0, n_beat = 0, n_done = 0, n_viol = 0;
    logic prev_ov = 1'b0, prev_rdy = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            s_if_wr <= 1'b0; s_if_rd <= 1'b0; s_of_wr <= 1'b0; s_of_rd <= 1'b0; s_pe <= 1'b0;
            prev_ov <= 1'b0; prev_rdy <= 1'b0;
        end else begin
            s_if_wr  <= if_fifo_ctrl[0];
            s_if_rd  <= if_fifo_ctrl[1];
            s_of_wr  <= of_fifo_ctrl[0];
            s_of_rd  <= of_fifo_ctrl[1];
            s_pe     <= pe_valid_o;
            prev_ov  <= out_valid_o;
            prev_rdy <= out_ready_i;
            if (if_fifo_ctrl[0]) n_if_wr <= n_if_wr + 1;
            if (if_fifo_ctrl[1]) n_if_rd <= n_if_rd + 1;
            if (of_fifo_ctrl[0]) n_of_wr <= n_of_wr + 1;
            if (of_fifo_ctrl[1]) n_of_rd <= n_of_rd + 1;
            if (out_valid_o && out_ready_i) n_beat <= n_beat + 1;
            if (done_o) n_done <= n_done + 1;
            if ((if_fifo_ctrl[0] && if_fifo_resp[0]) || (if_fifo_ctrl[1] && if_fifo_resp[1]) ||
                (of_fifo_ctrl[0] && of_fifo_resp[0]) || (of_fifo_ctrl[1] && of_fifo_resp[1]) ||
                ((if_fifo_ctrl != 2'b00 || of_fifo_ctrl != 2'b00) && (!busy_o || done_o)) ||
                (of_fifo_ctrl[1] && out_valid_o && !out_ready_i) ||
                (prev_ov && !prev_rdy && !out_valid_o))
                n_viol <= n_viol + 1;
        end
    end

    int n_chk = 0, n_err = 0;
    int b_if_wr, b_if_rd, b_of_wr, b_of_rd, b_beat, b_done, b_viol;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_if_wr = n_if_wr; b_if_rd = n_if_rd; b_of_wr = n_of_wr; b_of_rd = n_of_rd;
        b_beat  = n_beat;  b_done  = n_done;  b_viol  = n_viol;
    endtask

    task automatic start_tile(input logic [4:0] len);
        tile_len_i = len;
        start_i    = 1'b1;
        tick();
        start_i    = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int base;
        base = n_done;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (n_done != base) break;
        end
        tick();
        tick();
        check(tag, n_done - base, 1);
    endtask

    task automatic check_tile(input string tag, input int len);
        check({tag, "_if_wr"}, n_if_wr - b_if_wr, len);
        check({tag, "_if_rd"}, n_if_rd - b_if_rd, len);
        check({tag, "_beats"}, n_beat - b_beat, len);
        check({tag, "_viol"}, n_viol - b_viol, 0);
        check({tag, "_busy"}, busy_o, 0);
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; tile_len_i = '0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        force_if_full = 1'b0; force_of_full = 1'b0; pe_inject = 1'b0;
        #1;
        check("reset_outputs", {busy_o, done_o, err_o, in_ready_o, pe_valid_o, out_valid_o,
                                if_fifo_ctrl, of_fifo_ctrl}, 0);
        tick();
        rst = 1'b0;
        tick();

        // 1: basic tile
        in_valid_i = 1'b1; out_ready_i = 1'b1;
        snap();
        start_tile(5'd4);
        check("t1_busy", busy_o, 1);
        wait_done(200, "t1_done");
        check_tile("t1", 4);
        check("t1_of_wr", n_of_wr - b_of_wr, 4);
        check("t1_of_rd", n_of_rd - b_of_rd, 4);
        check("t1_err", err_o, 0);

        // 2: IF bank reports full mid-fill
        snap();
        start_tile(5'd16);
        for (int i = 0; i < 20; i++) begin
            if (n_if_wr - b_if_wr >= 2) break;
            tick();
        end
        force_if_full = 1'b1;
        #1;
        check("t2_ready_full", in_ready_o, 0);
        check("t2_wr_full", if_fifo_ctrl[0], 0);
        tick(); tick(); tick();
        check("t2_stalled_wr", n_if_wr - b_if_wr, 2);
        force_if_full = 1'b0;
        wait_done(400, "t2_done");
        check_tile("t2", 16);
        check("t2_of_wr", n_of_wr - b_of_wr, 16);

        // 3: downstream backpressure 1,0,0,1
        out_ready_i = 1'b0;
        snap();
        start_tile(5'd4);
        for (int i = 0; i < 200; i++) begin
            if (out_valid_o) break;
            tick();
        end
        check("t3_out_valid", out_valid_o, 1);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        #1;
        check("t3_hold0", {out_valid_o, of_fifo_ctrl[1]}, 2'b10);
        tick();
        check("t3_hold1", {out_valid_o, of_fifo_ctrl[1]}, 2'b10);
        out_ready_i = 1'b1;
        wait_done(200, "t3_done");
        check_tile("t3", 4);

        // 4: PE results while OF bank full
        force_of_full = 1'b1;
        snap();
        start_tile(5'd4);
        wait_done(200, "t4_done");
        check("t4_of_wr", n_of_wr - b_of_wr, 0);
        check("t4_err_sticky", err_o, 1);
        check("t4_viol", n_viol - b_viol, 0);
        force_of_full = 1'b0;
        snap();
        start_tile(5'd4);
        check("t4_err_cleared", err_o, 0);
        wait_done(200, "t4b_done");
        check_tile("t4b", 4);

        // 5: illegal lengths and start while busy
        start_tile(5'd0);
        check("t5_len0", {err_o, busy_o}, 2'b10);
        snap();
        start_tile(5'd4);
        check("t5_legal", {err_o, busy_o}, 2'b01);
        for (int i = 0; i < 50; i++) begin
            if (n_if_rd - b_if_rd >= 1) break;
            tick();
        end
        start_tile(5'd8);
        check("t5_ignored", {err_o, busy_o}, 2'b01);
        wait_done(200, "t5_done");
        check_tile("t5", 4);
        start_tile(5'd17);
        check("t5_len17", {err_o, busy_o}, 2'b10);

        // 6: reset mid-compute, then a clean tile and a stray PE result in IDLE
        snap();
        start_tile(5'd8);
        for (int i = 0; i < 50; i++) begin
            if (n_if_rd - b_if_rd >= 1) break;
            tick();
        end
        rst = 1'b1;
        #1;
        check("t6_rst_outputs", {busy_o, done_o, err_o, in_ready_o, pe_valid_o, out_valid_o,
                                 if_fifo_ctrl, of_fifo_ctrl}, 0);
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        check("t6_no_done", n_done - b_done, 0);
        check("t6_idle", busy_o, 0);
        snap();
        start_tile(5'd4);
        wait_done(200, "t6_done");
        check_tile("t6", 4);
        check("t6_err", err_o, 0);
        pe_inject = 1'b1;
        tick();
        pe_inject = 1'b0;
        check("t6_stray_result", err_o, 1);
        start_tile(5'd2);
        check("t6_start_clears", err_o, 0);
        wait_done(200, "t6b_done");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
